// File: rtl/alu_ctrl_pkg.sv
// Purpose: shared encodings for the execute controller (opcodes, FSM states, flag bits).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_ctrl_pkg;

    // Primary opcodes, instr[15:12]
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDUI = 4'b0110;
    localparam logic [3:0] OP_ADDCI = 4'b0111;
    localparam logic [3:0] OP_EXT   = 4'b1010;

    // Opcode extensions, instr[7:4]
    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_ADDU = 4'b0110;
    localparam logic [3:0] EXT_ADDC = 4'b0111;

    // CLFZN bit positions inside alu_flags / psr_flags
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    // Operand-B source chosen during DECODE
    typedef enum logic [1:0] {
        BSEL_REG  = 2'd0,
        BSEL_SEXT8 = 2'd1,
        BSEL_ZEXT8 = 2'd2,
        BSEL_ZEXT4 = 2'd3
    } bsel_t;

endpackage

// File: rtl/alu_exec_ctrl_regfile.sv
// Purpose: NREGS x DW register file, two async read ports for operands plus one debug read port.
// Latency: reads combinational; write lands at the rising edge with we high.
// Backpressure: none, a write is always accepted.
module regfile_16x16 #(
    parameter int NREGS = 16,
    parameter int DW    = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b,
    input  logic [AW-1:0] raddr_d,
    output logic [DW-1:0] rdata_d
);

    logic [DW-1:0] mem [NREGS];

    // Storage: async clear, single synchronous write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
    assign rdata_d = mem[raddr_d];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Purpose: execute controller: decode one instruction, drive the external ALU, write back result and PSR.
// Latency: accept edge E, done during cycle E+2..E+3, result visible from edge E+3; one instruction per 4 cycles.
// Backpressure: instr_ready only in IDLE; instr_valid ignored in every other state, nothing is queued.
module alu_exec_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    input  logic [15:0]   instr,
    output logic          instr_ready,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_opcode,
    output logic [3:0]    alu_opext,
    input  logic [DW-1:0] alu_s,
    input  logic [4:0]    alu_flags,
    output logic          done,
    output logic          err,
    output logic [4:0]    psr_flags,
    input  logic [3:0]    dbg_raddr,
    output logic [DW-1:0] dbg_rdata
);

    state_t        state, state_nxt;
    logic [15:0]   instr_q;
    logic          unsup_q;
    logic [DW-1:0] res_q;
    logic [4:0]    flags_q;
    logic [DW-1:0] rd_val, rs_val;
    logic [DW-1:0] b_val;
    logic          supported;
    bsel_t         bsel;
    logic          rf_we;

    wire [3:0] f_opc = instr_q[15:12];
    wire [3:0] f_rd  = instr_q[11:8];
    wire [3:0] f_ext = instr_q[7:4];
    wire [3:0] f_rs  = instr_q[3:0];

    wire accept = instr_valid & instr_ready;

    regfile_16x16 #(.NREGS(NREGS), .DW(DW)) u_rf (
        .clk     (clk),
        .reset   (reset),
        .we      (rf_we),
        .waddr   (f_rd),
        .wdata   (res_q),
        .raddr_a (f_rd),
        .rdata_a (rd_val),
        .raddr_b (f_rs),
        .rdata_b (rs_val),
        .raddr_d (dbg_raddr),
        .rdata_d (dbg_rdata)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: fixed one-cycle walk through the pipeline steps
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = ST_WB;
            ST_WB:     state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs; ready is masked by reset so it stays low while reset is held
    always_comb begin
        instr_ready = (state == ST_IDLE) && !reset;
        done        = (state == ST_WB);
        err         = (state == ST_WB) && unsup_q;
        rf_we       = (state == ST_WB) && !unsup_q;
    end

    // Decode: classify the encoding and pick the operand-B source
    always_comb begin
        supported = 1'b1;
        bsel      = BSEL_REG;
        case (f_opc)
            OP_RTYPE: begin
                case (f_ext)
                    EXT_AND, EXT_OR, EXT_ADD, EXT_ADDU, EXT_ADDC: bsel = BSEL_REG;
                    default: supported = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDCI: bsel = BSEL_SEXT8;
            OP_ADDUI:          bsel = BSEL_ZEXT8;
            OP_EXT: begin
                case (f_ext)
                    EXT_ADD:  bsel = BSEL_REG;
                    EXT_ADDU: bsel = BSEL_ZEXT4;
                    default:  supported = 1'b0;
                endcase
            end
            default: supported = 1'b0;
        endcase
    end

    // Operand-B mux driven by the decoded source
    always_comb begin
        case (bsel)
            BSEL_SEXT8: b_val = {{(DW-8){instr_q[7]}}, instr_q[7:0]};
            BSEL_ZEXT8: b_val = {{(DW-8){1'b0}}, instr_q[7:0]};
            BSEL_ZEXT4: b_val = {{(DW-4){1'b0}}, instr_q[3:0]};
            default:    b_val = rs_val;
        endcase
    end

    // Datapath registers: latch instr on accept, ALU inputs at end of DECODE, ALU outputs at end of EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q    <= '0;
            unsup_q    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_opext  <= '0;
            res_q      <= '0;
            flags_q    <= '0;
        end else begin
            if (accept) instr_q <= instr;
            if (state == ST_DECODE) begin
                alu_a      <= rd_val;
                alu_b      <= b_val;
                alu_opcode <= f_opc;
                alu_opext  <= f_ext;
                unsup_q    <= !supported;
            end
            if (state == ST_EXEC) begin
                res_q   <= alu_s;
                flags_q <= alu_flags;
            end
        end
    end

    // PSR: whole CLFZN word replaced on a supported writeback
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      psr_flags <= '0;
        else if (rf_we) psr_flags <= flags_q;
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Purpose: directed self-checking bench for alu_exec_ctrl with a behavioural adder standing in for the ALU.
// Latency: checks sampled on falling edges, accept edge E -> done at the third falling edge after E.
// Backpressure: instr_valid driven only when instr_ready is expected high, except the back-to-back step.
module tb_alu_exec_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_opcode, alu_opext;
    logic [15:0] alu_s;
    logic [4:0]  alu_flags;
    logic        done, err;
    logic [4:0]  psr_flags;
    logic [3:0]  dbg_raddr;
    logic [15:0] dbg_rdata;

    logic        force_alu;
    int          nerr = 0;
    int          nchk = 0;
    int          lows;
    logic [15:0] rv;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_opext   (alu_opext),
        .alu_s       (alu_s),
        .alu_flags   (alu_flags),
        .done        (done),
        .err         (err),
        .psr_flags   (psr_flags),
        .dbg_raddr   (dbg_raddr),
        .dbg_rdata   (dbg_rdata)
    );

    // ALU stand-in: either a fixed answer or a plain adder with C, Z, N flags
    always_comb begin
        logic [16:0] sum;
        sum = {1'b0, alu_a} + {1'b0, alu_b};
        if (force_alu) begin
            alu_s     = 16'h0000;
            alu_flags = 5'b00010;
        end else begin
            alu_s     = sum[15:0];
            alu_flags = {sum[16], 1'b0, 1'b0, (sum[15:0] == 16'h0), sum[15]};
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rdreg(input logic [3:0] r, output logic [15:0] v);
        dbg_raddr = r;
        #1;
        v = dbg_rdata;
    endtask

    // Handshake one instruction and check the ALU drive and done/err; returns at the WB falling edge
    task automatic issue(input string tag, input logic [15:0] ins, input logic [15:0] ea,
                         input logic [15:0] eb, input logic [3:0] eop, input logic eerr);
        @(negedge clk);
        chk({tag, "_ready"}, {15'b0, instr_ready}, 16'd1);
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'h0;
        chk({tag, "_decode_busy"}, {14'b0, instr_ready, done}, 16'd0);
        @(negedge clk);
        chk({tag, "_alu_a"}, alu_a, ea);
        chk({tag, "_alu_b"}, alu_b, eb);
        chk({tag, "_opcode"}, {12'b0, alu_opcode}, {12'b0, eop});
        chk({tag, "_exec_done"}, {15'b0, done}, 16'd0);
        @(negedge clk);
        chk({tag, "_done"}, {15'b0, done}, 16'd1);
        chk({tag, "_err"}, {15'b0, err}, {15'b0, eerr});
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0;
        dbg_raddr   = 4'h0;
        force_alu   = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {15'b0, instr_ready}, 16'd0);
        chk("rst_done_err", {14'b0, done, err}, 16'd0);
        chk("rst_psr", {11'b0, psr_flags}, 16'd0);
        chk("rst_alu_a", alu_a, 16'd0);
        chk("rst_alu_b", alu_b, 16'd0);
        chk("rst_alu_op", {8'b0, alu_opcode, alu_opext}, 16'd0);
        rdreg(4'd1, rv);
        chk("rst_r1", rv, 16'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_ready", {15'b0, instr_ready}, 16'd1);

        // ADD R1,R2 with fixed ALU answer S=0 flags=00010
        issue("add", 16'h0152, 16'h0000, 16'h0000, 4'h0, 1'b0);
        @(negedge clk);
        rdreg(4'd1, rv);
        chk("add_r1", rv, 16'h0000);
        chk("add_psr", {11'b0, psr_flags}, 16'h0002);
        force_alu = 1'b0;

        // ADDUI R4,#0xFF: zero-extended immediate; old value during WB, new after the edge
        issue("addui", 16'h64FF, 16'h0000, 16'h00FF, 4'h6, 1'b0);
        rdreg(4'd4, rv);
        chk("addui_r4_wb_old", rv, 16'h0000);
        @(negedge clk);
        rdreg(4'd4, rv);
        chk("addui_r4", rv, 16'h00FF);
        chk("addui_psr", {11'b0, psr_flags}, 16'h0000);

        // ADDI R3,#0xFF: sign-extended to 0xFFFF
        issue("addi_ff", 16'h53FF, 16'h0000, 16'hFFFF, 4'h5, 1'b0);
        @(negedge clk);
        rdreg(4'd3, rv);
        chk("addi_ff_r3", rv, 16'hFFFF);
        chk("addi_ff_psr", {11'b0, psr_flags}, 16'h0001);

        // ADDI R3,#0x01: 0xFFFF + 1 wraps to 0 with carry and zero
        issue("addi_01", 16'h5301, 16'hFFFF, 16'h0001, 4'h5, 1'b0);
        @(negedge clk);
        rdreg(4'd3, rv);
        chk("addi_01_r3", rv, 16'h0000);
        chk("addi_01_psr", {11'b0, psr_flags}, 16'h0012);

        // Unsupported 0000_0100 on R4: no write, PSR kept
        issue("unsup", 16'h0444, 16'h00FF, 16'h00FF, 4'h0, 1'b1);
        @(negedge clk);
        rdreg(4'd4, rv);
        chk("unsup_r4", rv, 16'h00FF);
        chk("unsup_psr", {11'b0, psr_flags}, 16'h0012);

        // ADDCUI R5,#0xF: 4-bit zero-extended immediate
        issue("addcui", 16'hA56F, 16'h0000, 16'h000F, 4'hA, 1'b0);
        @(negedge clk);
        chk("addcui_opext_held", {12'b0, alu_opext}, 16'h0006);
        rdreg(4'd5, rv);
        chk("addcui_r5", rv, 16'h000F);
        chk("addcui_psr", {11'b0, psr_flags}, 16'h0000);

        // Back-to-back: ADD R4,R4 then ADD R4,R5 with instr_valid held high
        instr_valid = 1'b1;
        instr       = 16'h0454;
        @(posedge clk);
        @(negedge clk);
        instr = 16'h0455;
        lows  = 0;
        for (int i = 0; i < 10 && !instr_ready; i++) begin
            lows++;
            @(negedge clk);
        end
        chk("b2b_ready_low_cycles", lows[15:0], 16'd3);
        rdreg(4'd4, rv);
        chk("b2b_first_r4", rv, 16'h01FE);
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'h0;
        @(negedge clk);
        chk("b2b_dep_alu_a", alu_a, 16'h01FE);
        chk("b2b_dep_alu_b", alu_b, 16'h000F);
        @(negedge clk);
        chk("b2b_done", {15'b0, done}, 16'd1);
        @(negedge clk);
        rdreg(4'd4, rv);
        chk("b2b_second_r4", rv, 16'h020D);

        // Reset asserted during EXEC
        instr_valid = 1'b1;
        instr       = 16'h0454;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'h0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_ready", {15'b0, instr_ready}, 16'd0);
        @(negedge clk);
        chk("midrst_done", {15'b0, done}, 16'd0);
        chk("midrst_psr", {11'b0, psr_flags}, 16'd0);
        rdreg(4'd4, rv);
        chk("midrst_r4", rv, 16'd0);
        rdreg(4'd5, rv);
        chk("midrst_r5", rv, 16'd0);
        chk("midrst_alu_a", alu_a, 16'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_rel_ready", {15'b0, instr_ready}, 16'd1);
        chk("midrst_rel_done", {15'b0, done}, 16'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
